// File: rtl/ahb_line_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_line_master
// Description : Cache-line bus master. Accepts one fill or writeback request
//               at a time, performs a single 128-bit transfer on the bus
//               and reports completion with a one-cycle response pulse.
//               Optional feature macro: BUS_TIMEOUT_EN (abandons a transfer
//               after TIMEOUT_CYCLES wait cycles and flags resp_err).
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_line_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         resp_err,
  output logic [31:0]  HADDR,
  output logic         HWRITE,
  output logic [127:0] HWDATA,
  input  logic [127:0] HRDATA,
  input  logic         HREADY
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Reject out-of-range timeout limits at elaboration time.
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
      $error("ahb_line_master: TIMEOUT_CYCLES must be in 1..255");
    end
  endgenerate

  logic [1:0]   state_q,  state_d;
  logic         write_q,  write_d;
  logic [31:0]  haddr_q,  haddr_d;
  logic [127:0] hwdata_q, hwdata_d;
  logic [127:0] rdata_q,  rdata_d;

`ifdef BUS_TIMEOUT_EN
  // Count value seen in the last allowed wait cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0]   cnt_q,    cnt_d;
  logic         err_q,    err_d;
`endif

  // Next-state and datapath capture logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          haddr_d  = {req_addr[31:4], 4'b0000};
          hwdata_d = req_wdata;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // HREADY is deliberately not looked at here: a level left over from
        // the previous transfer must not complete this one.
        state_d = ST_WAIT;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_WAIT: begin
        if (HREADY) begin
          rdata_d = write_q ? 128'd0 : HRDATA;
`ifdef BUS_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = 128'd0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      haddr_q  <= 32'd0;
      hwdata_q <= 128'd0;
      rdata_q  <= 128'd0;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs are flops or pure decodes of the state register.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign HADDR      = haddr_q;
  assign HWDATA     = hwdata_q;
  assign HWRITE     = write_q && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));

`ifdef BUS_TIMEOUT_EN
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_line_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_line_master
// Description : Directed self-checking bench for ahb_line_master. Expected
//               responses are queued when a request is issued and checked
//               by a response monitor. Honours BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_line_master;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         req_valid;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_rdata;
  logic         resp_err;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [127:0] HWDATA;
  logic [127:0] HRDATA;
  logic         HREADY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int resp_cnt = 0;
  int exp_resp_cnt = 0;

  typedef struct packed {
    logic [127:0] rdata;
    logic         err;
  } resp_t;
  resp_t sb[$];

  ahb_line_master #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .HADDR      (HADDR),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY)
  );

  always #5 HCLK = ~HCLK;

  // Cycle counter: value equals number of rising edges seen.
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && resp_valid === 1'b1) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 128'd1, 128'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {127'd0, resp_err}, {127'd0, e.err});
      end
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Drive one request; returns the edge count at which it was accepted.
  task automatic send(input logic w, input logic [31:0] a, input logic [127:0] d, output int acc);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", {127'd0, req_ready}, 128'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  // Tick until resp_valid is seen or the budget runs out.
  task automatic wait_resp(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (resp_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("resp_seen", {127'd0, (at >= 0)}, 128'd1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_req_ready"},  {127'd0, req_ready},  128'd1);
    chk({pfx, "_resp_valid"}, {127'd0, resp_valid}, 128'd0);
    chk({pfx, "_resp_rdata"}, resp_rdata,           128'd0);
    chk({pfx, "_resp_err"},   {127'd0, resp_err},   128'd0);
    chk({pfx, "_haddr"},      {96'd0, HADDR},       128'd0);
    chk({pfx, "_hwrite"},     {127'd0, HWRITE},     128'd0);
    chk({pfx, "_hwdata"},     HWDATA,               128'd0);
  endtask

  initial begin : stim
    int acc, acc2, at, at2;
    logic [127:0] fill_data, wb_data, d1, d2, d3;
    fill_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    wb_data   = 128'h44444444_33333333_22222222_11111111;
    d1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    d2 = 128'hCAFEF00D_DEADBEEF_12345678_9ABCDEF0;
    d3 = 128'h55AA55AA_0F0F0F0F_F0F0F0F0_AA55AA55;

    HRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 128'd0; HRDATA = 128'd0; HREADY = 1'b0;

    // Reset state
    tick(); tick();
    chk_reset_outputs("rst");
    HRESETn = 1'b1;
    tick();

    // Fill with HREADY arriving in the second WAIT cycle
    HREADY = 1'b0;
    send(1'b0, 32'h0000_1234, 128'h0, acc);
    sb.push_back('{rdata: fill_data, err: 1'b0}); exp_resp_cnt++;
    chk("fill_issue_haddr",  {96'd0, HADDR}, 128'h1230);
    chk("fill_issue_hwrite", {127'd0, HWRITE}, 128'd0);
    chk("fill_issue_ready",  {127'd0, req_ready}, 128'd0);
    tick();
    chk("fill_wait1_haddr",  {96'd0, HADDR}, 128'h1230);
    chk("fill_wait1_hwrite", {127'd0, HWRITE}, 128'd0);
    chk("fill_wait1_valid",  {127'd0, resp_valid}, 128'd0);
    tick();
    HREADY = 1'b1;
    HRDATA = fill_data;
    tick();
    chk("fill_resp_valid",   {127'd0, resp_valid}, 128'd1);
    chk("fill_resp_cycle",   128'(cyc - acc), 128'd3);
    chk("fill_resp_hwrite",  {127'd0, HWRITE}, 128'd0);
    HREADY = 1'b0;
    tick();
    chk("fill_idle_valid",   {127'd0, resp_valid}, 128'd0);
    chk("fill_idle_ready",   {127'd0, req_ready}, 128'd1);
    chk("fill_rdata_hold",   resp_rdata, fill_data);
    chk("fill_idle_haddr",   {96'd0, HADDR}, 128'h1230);

    // Writeback, HREADY high from ISSUE so it is seen in the first WAIT cycle
    send(1'b1, 32'h0000_0040, wb_data, acc);
    sb.push_back('{rdata: 128'd0, err: 1'b0}); exp_resp_cnt++;
    chk("wb_issue_hwrite", {127'd0, HWRITE}, 128'd1);
    chk("wb_issue_hwdata", HWDATA, wb_data);
    chk("wb_issue_haddr",  {96'd0, HADDR}, 128'h40);
    HREADY = 1'b1;
    HRDATA = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    tick();
    chk("wb_wait_hwrite",  {127'd0, HWRITE}, 128'd1);
    chk("wb_wait_hwdata",  HWDATA, wb_data);
    tick();
    chk("wb_resp_valid",   {127'd0, resp_valid}, 128'd1);
    chk("wb_resp_cycle",   128'(cyc - acc), 128'd2);
    chk("wb_resp_hwrite",  {127'd0, HWRITE}, 128'd0);
    tick();
    chk("wb_idle_hwrite",  {127'd0, HWRITE}, 128'd0);
    chk("wb_idle_hwdata",  HWDATA, wb_data);

    // Stale HREADY held high: back-to-back fills complete 4 cycles apart
    HREADY = 1'b1;
    HRDATA = d1;
    send(1'b0, 32'h0000_0100, 128'h0, acc);
    sb.push_back('{rdata: d1, err: 1'b0}); exp_resp_cnt++;
    chk("stale1_issue_valid", {127'd0, resp_valid}, 128'd0);
    wait_resp(10, at);
    chk("stale1_latency", 128'(at - acc), 128'd2);
    HRDATA = d2;
    send(1'b0, 32'h0000_0200, 128'h0, acc2);
    sb.push_back('{rdata: d2, err: 1'b0}); exp_resp_cnt++;
    chk("stale_accept_gap", 128'(acc2 - acc), 128'd4);
    wait_resp(10, at2);
    chk("stale_resp_gap", 128'(at2 - at), 128'd4);
    tick();

    // Timeout with HREADY never asserted
    HREADY = 1'b0;
    HRDATA = d3;
    send(1'b0, 32'h0000_0300, 128'h0, acc);
`ifdef BUS_TIMEOUT_EN
    sb.push_back('{rdata: 128'd0, err: 1'b1}); exp_resp_cnt++;
    wait_resp(20, at);
    chk("to_latency", 128'(at - acc), 128'd5);
    chk("to_err", {127'd0, resp_err}, 128'd1);
    chk("to_rdata", resp_rdata, 128'd0);
    tick();
`else
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (resp_valid === 1'b1) seen++;
      end
      chk("noto_no_resp", 128'(seen), 128'd0);
      chk("noto_stuck_ready", {127'd0, req_ready}, 128'd0);
      HRESETn = 1'b0;
      tick();
      chk_reset_outputs("noto_rst");
      HRESETn = 1'b1;
    end
`endif

    // Reset while waiting on a fill: no response, outputs return to reset
    HREADY = 1'b0;
    HRDATA = d3;
    send(1'b0, 32'h0000_0400, 128'hABCD, acc);
    tick();
    chk("rstw_in_wait_ready", {127'd0, req_ready}, 128'd0);
    HRESETn = 1'b0;
    tick();
    chk_reset_outputs("rstw");
    HRESETn = 1'b1;
    HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstw_quiet_valid", {127'd0, resp_valid}, 128'd0);
    end

    // Recovery fill after reset
    HRDATA = d2 ^ d1;
    send(1'b0, 32'h0000_050C, 128'h0, acc);
    sb.push_back('{rdata: d2 ^ d1, err: 1'b0}); exp_resp_cnt++;
    chk("rec_haddr", {96'd0, HADDR}, 128'h500);
    wait_resp(10, at);
    chk("rec_latency", 128'(at - acc), 128'd2);
    tick(); tick();

    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("resp_count", 128'(resp_cnt), 128'(exp_resp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_line_master.md
# ahb_line_master

Bus master that sits directly upstream of the AHB-Lite memory subsystem in the pipelined ARM core. It accepts one cache-line request at a time from the cache controller: either a line fill (read) or a line writeback (write). It drives the single-transfer, 4-word-wide bus (HADDR/HWRITE/HWDATA), waits for HREADY, and returns the 128-bit line with a one-cycle response pulse.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before the transfer is abandoned. Used only when the timeout feature is compiled in. Legal range 1..255.

Ports:
- HCLK  in  1  clock; all state updates on the rising edge
- HRESETn  in  1  reset, synchronous, active-low
- req_valid  in  1  cache controller presents a request
- req_write  in  1  1 = writeback, 0 = fill
- req_addr  in  32  byte address; bits [3:0] are ignored
- req_wdata  in  128  writeback line; word 0 in bits [31:0]
- req_ready  out  1  block can accept a request
- resp_valid  out  1  one-cycle pulse marking completion
- resp_rdata  out  128  fill data, valid while resp_valid=1
- resp_err  out  1  transfer timed out, valid while resp_valid=1
- HADDR  out  32  bus address, always line aligned
- HWRITE  out  1  bus write strobe
- HWDATA  out  128  bus write data
- HRDATA  in  128  bus read data
- HREADY  in  1  bus completion/valid from memory

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture req_write, {req_addr[31:4],4'b0} and req_wdata, then go to ISSUE.
- ISSUE (exactly one cycle):
  - HADDR = captured address; HWRITE = captured write flag; HWDATA = captured data.
  - HREADY is ignored, so a stale HREADY left over from a previous transfer is never taken.
  - Go to WAIT.
- WAIT:
  - Bus outputs are held unchanged.
  - On HREADY=1, register HRDATA into resp_rdata (fills only; writebacks load 0), clear the error flag, and go to RESP.
- RESP (exactly one cycle):
  - resp_valid=1 and HWRITE=0.
  - Go to IDLE.
- Outside ISSUE and WAIT:
  - HWRITE=0.
  - HADDR and HWDATA hold their last values, so any read side effect stays at a harmless, already-used address.
- resp_rdata and resp_err hold their values after RESP until the next response.
- req_ready=0 in ISSUE, WAIT and RESP. A req_valid asserted in those states is not captured; the requester must hold it until it sees req_ready=1.
- Reset values:
  - req_ready=1
  - resp_valid=0
  - resp_rdata=0
  - resp_err=0
  - HADDR=0
  - HWRITE=0
  - HWDATA=0
- Reset mid-transfer: on the next edge the FSM goes to IDLE and all outputs take their reset values. No response is issued. Whether memory committed an in-flight writeback is undefined.

## Timing
- Request accepted at edge N (IDLE with req_valid=1): ISSUE occupies cycle N+1 and WAIT starts at N+2.
- Minimum latency: HREADY=1 in the first WAIT cycle gives resp_valid=1 in cycle N+3, with req_ready=1 again in N+4. A new request can therefore be accepted 4 cycles after the previous one.
- Each extra WAIT cycle (HREADY=0) adds one cycle of latency.
- There are no combinational paths from inputs to outputs; every output is registered or decoded from the FSM state.

## Configuration
- BUS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments every WAIT cycle with HREADY=0.
  - When the count reaches TIMEOUT_CYCLES with HREADY still 0, go to RESP with resp_err=1 and resp_rdata=0.
  - HREADY=1 in the same cycle the limit is reached takes priority: normal completion, resp_err=0.
- BUS_TIMEOUT_EN undefined:
  - No counter; WAIT lasts indefinitely.
  - resp_err is constant 0.

## Test plan
- Fill: req_addr=0x0000_1234, req_write=0; HREADY rises 2 cycles into WAIT with HRDATA=0xDDDD..AAAA. Required: HADDR=0x0000_1230, HWRITE=0 throughout, one resp_valid pulse with resp_rdata=0xDDDD..AAAA and resp_err=0.
- Writeback: req_addr=0x40, req_wdata=0x4444_4444_3333_3333_2222_2222_1111_1111, HREADY=1 in the first WAIT cycle. Required: HWRITE=1 in ISSUE and WAIT only, HWDATA equals req_wdata, resp_valid in cycle N+3.
- Stale HREADY: HREADY held at 1 continuously. Required: completion still occurs no earlier than N+3, and back-to-back requests complete 4 cycles apart.
- Timeout (macro on, TIMEOUT_CYCLES=4, HREADY=0): resp_valid with resp_err=1 and resp_rdata=0 after 4 WAIT cycles. Same stimulus with the macro off: no response within 300 cycles.
- Reset in WAIT: pull HRESETn low for one edge mid-fill. Required: the next cycle shows all outputs at reset values, no resp_valid, and a following request completes normally.
